microwave_timer_ctrl: RTL
=========================

# microwave_timer_ctrl

Sequencing controller for the microwave's MM:SS countdown. It accepts keypad digits into a four-digit BCD time register and runs start/pause/cancel control with a door interlock. It generates the 1 s decrement tick with borrow across the mixed-radix digits. It drives the magnetron enable and a one-cycle completion pulse. It sits between the keypad/button debouncers and the display/magnetron drivers.

## Interface
- TICK_DIV, 50000000: clock cycles per 1 s countdown tick (≥2).
- clk  in  1  system clock, all state on rising edge.
- clrn  in  1  asynchronous, active-low reset.
- digit_valid  in  1  one-cycle strobe, keypad digit present.
- digit  in  4  BCD keypad value; values >9 are ignored.
- key_start  in  1  one-cycle start/resume strobe.
- key_stop  in  1  one-cycle stop/clear strobe.
- door_closed  in  1  level; 1 = door shut.
- mm_tens, mm_ones, ss_tens, ss_ones  out  4 each  current BCD time.
- state  out  3  current FSM state.
- mag_on  out  1  magnetron enable, registered.
- done  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE (time 00:00), SET (digits entered), RUN, PAUSE, DONE.
- Digit entry is accepted in IDLE, SET and DONE only:
  - shift left: mm_tens←mm_ones, mm_ones←ss_tens, ss_tens←ss_ones, ss_ones←digit; the old mm_tens is discarded.
  - Entry from DONE first clears the time, then shifts the digit in.
  - Any accepted digit moves the FSM to SET.
- Start:
  - SET with nonzero time and door_closed → RUN.
  - PAUSE with door_closed → RUN, with time unchanged.
  - IDLE, or SET with zero time: see Configuration.
  - Ignored in RUN and DONE, and whenever door_closed=0.
- Stop:
  - RUN → PAUSE.
  - PAUSE, SET, DONE → IDLE, with all digits cleared.
  - Ignored in IDLE.
- Door open while in RUN → PAUSE.
- Decrement on each tick while in RUN:
  - ss_ones 0→9 with borrow; ss_tens 0→5 with borrow; mm_ones 0→9 with borrow; mm_tens decrements.
  - Entered seconds 60–99 are legal and count down as entered. Example: 01:75 → 01:74 … 01:00 → 00:59.
  - A decrement that yields 00:00 moves the FSM to DONE on the same edge.
- Priority within one cycle: clrn > door open > key_stop > key_start > digit_valid > tick. Example: stop and tick together in RUN gives PAUSE with no decrement.

## Timing
- Reset values: digits 0, state IDLE, mag_on 0, done 0, prescaler 0.
- All inputs are sampled on the rising edge. Their effect is visible in the outputs one cycle later.
- Prescaler:
  - Cleared on every entry to RUN and held at 0 outside RUN.
  - The first decrement occurs exactly TICK_DIV cycles after the start edge.
  - Resuming from PAUSE restarts a full second; partial seconds are lost.
- mag_on is 1 exactly while state==RUN. It falls on the same edge RUN is left, including the edge on which the door opens.
- done is high for the single cycle following the edge that entered DONE.
- Asynchronous reset mid-RUN: mag_on drops immediately and the time is lost.
- digit_valid is ignored in RUN and PAUSE.

## Configuration
- QUICK_START_EN defined:
  - key_start in IDLE, or in SET with time 00:00, loads 00:30 and enters RUN (door closed).
  - key_start in SET with nonzero time behaves as normal.
- QUICK_START_EN undefined: key_start with zero time is ignored and the state does not change.

## Structure
- Shared package timer_pkg holds:
  - state encodings: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4;
  - the quick-start constant 00:30 as four BCD digits;
  - the BCD limits 9 and 5.
- One sub-module, tick_prescaler (parameter TICK_DIV; inputs clk, clrn, run; output tick), a single-cycle pulse every TICK_DIV cycles while run=1.
- Digit register, borrow chain and FSM stay in microwave_timer_ctrl.

## Test plan
Bench uses TICK_DIV=4.
- Entry and countdown: reset; digits 1,3,0; start (door closed) → time 01:30 and RUN. First decrement to 01:29 is 4 cycles after start; 01:00 → 00:59 borrow is correct.
- Completion: enter 0,0,0,2; start → after 8 cycles time 00:00, state DONE, mag_on=0, done high for exactly one cycle.
- Door interlock: door opens mid-RUN at 00:05 → PAUSE next edge, mag_on=0, time frozen. Start while door open is ignored. Door closes, start → RUN; next decrement is 4 cycles later.
- Stop/clear: RUN at 02:00, stop → PAUSE at 02:00; stop again → IDLE, 00:00. Stop and tick in the same cycle → no decrement.
- Entry overflow/invalid: digits 1,2,3,4,5 → 23:45. Digit 0xA is ignored. 0,0,7,5 entered with start → 00:74 after one tick.
- Quick start: IDLE, start → with QUICK_START_EN time 00:30 and RUN. Without QUICK_START_EN state stays IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave countdown controller: state
// encodings, the MM:SS BCD time record, BCD digit limits and the digit helpers.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] mm_tens;
    logic [3:0] mm_ones;
    logic [3:0] ss_tens;
    logic [3:0] ss_ones;
  } bcd_time_t;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  localparam bcd_time_t QUICK_TIME = '{mm_tens: 4'd0, mm_ones: 4'd0,
                                       ss_tens: 4'd3, ss_ones: 4'd0};

  // Mixed-radix decrement; callers guarantee the time is nonzero.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    logic      b;
    r = t;
    b = (t.ss_ones == 4'd0);
    r.ss_ones = b ? BCD_ONES_MAX : t.ss_ones - 4'd1;
    if (b) begin
      b = (t.ss_tens == 4'd0);
      r.ss_tens = b ? BCD_TENS_MAX : t.ss_tens - 4'd1;
    end
    if (b) begin
      b = (t.mm_ones == 4'd0);
      r.mm_ones = b ? BCD_ONES_MAX : t.mm_ones - 4'd1;
    end
    if (b) r.mm_tens = t.mm_tens - 4'd1;
    return r;
  endfunction

  function automatic bcd_time_t bcd_shift_in(input bcd_time_t t, input logic [3:0] d);
    return '{mm_tens: t.mm_ones, mm_ones: t.ss_tens, ss_tens: t.ss_ones, ss_ones: d};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: a single-cycle pulse every TICK_DIV cycles while
// run is high; the count is held at zero whenever run is low.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic clrn,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = run && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (run && !tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// MM:SS microwave countdown controller: keypad entry, start/pause/cancel FSM,
// door interlock and magnetron enable. Optional feature macro: QUICK_START_EN.
module microwave_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       key_start,
  input  logic       key_stop,
  input  logic       door_closed,
  output logic [3:0] mm_tens,
  output logic [3:0] mm_ones,
  output logic [3:0] ss_tens,
  output logic [3:0] ss_ones,
  output logic [2:0] state,
  output logic       mag_on,
  output logic       done
);

  state_e    state_q;
  bcd_time_t time_q;
  logic      mag_on_q;
  logic      done_q;

  logic      tick;
  logic      time_nz;
  logic      digit_ok;
  logic      start_ok;
  bcd_time_t time_dec;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .clrn (clrn),
    .run  (state_q == ST_RUN),
    .tick (tick)
  );

  assign time_nz  = |time_q;
  assign digit_ok = digit_valid && (digit <= BCD_ONES_MAX);
  assign start_ok = key_start && door_closed;
  assign time_dec = bcd_dec(time_q);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      time_q   <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mag_on_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_SET, ST_DONE: begin
          if (key_stop && state_q != ST_IDLE) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
          end else if (start_ok && state_q == ST_SET && time_nz) begin
            state_q  <= ST_RUN;
            mag_on_q <= 1'b1;
`ifdef QUICK_START_EN
          end else if (start_ok && state_q != ST_DONE && !time_nz) begin
            state_q  <= ST_RUN;
            time_q   <= QUICK_TIME;
            mag_on_q <= 1'b1;
`endif
          end else if (digit_ok) begin
            // A fresh entry after completion starts from 00:00.
            time_q  <= bcd_shift_in((state_q == ST_DONE) ? bcd_time_t'('0) : time_q, digit);
            state_q <= ST_SET;
          end
        end
        ST_RUN: begin
          if (!door_closed || key_stop) begin
            state_q <= ST_PAUSE;
          end else if (tick) begin
            time_q <= time_dec;
            if (time_dec == bcd_time_t'('0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              mag_on_q <= 1'b1;
            end
          end else begin
            mag_on_q <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (key_stop) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
          end else if (start_ok) begin
            state_q  <= ST_RUN;
            mag_on_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          time_q  <= '0;
        end
      endcase
    end
  end

  assign mm_tens = time_q.mm_tens;
  assign mm_ones = time_q.mm_ones;
  assign ss_tens = time_q.ss_tens;
  assign ss_ones = time_q.ss_ones;
  assign state   = state_q;
  assign mag_on  = mag_on_q;
  assign done    = done_q;

endmodule
